// File: rtl/rs_bank_if.sv
// rs_bank_if: dispatch, CDB snoop and issue signals of one reservation-station bank.
//   dispatch_* : decode/rename offers one instruction per cycle (valid/ready)
//   cdb_*      : one common-data-bus broadcast per cycle
//   issue_*    : selected ready entry to execute (valid/ready)
// Modports:
//   master : the pipeline side (drives dispatch, CDB and issue_ready)
//   slave  : the reservation-station bank
interface rs_bank_if #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 64
);
    logic                 dispatch_valid;
    logic                 dispatch_ready;
    logic [TAG_W-1:0]     dispatch_dest_tag;
    logic [TAG_W-1:0]     dispatch_rs1_tag;
    logic [XLEN-1:0]      dispatch_rs1_value;
    logic [TAG_W-1:0]     dispatch_rs2_tag;
    logic [XLEN-1:0]      dispatch_rs2_value;
    logic [PAYLOAD_W-1:0] dispatch_payload;

    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [XLEN-1:0]      cdb_value;

    logic                 issue_valid;
    logic                 issue_ready;
    logic [TAG_W-1:0]     issue_dest_tag;
    logic [XLEN-1:0]      issue_rs1_value;
    logic [XLEN-1:0]      issue_rs2_value;
    logic [PAYLOAD_W-1:0] issue_payload;

    modport master (
        output dispatch_valid, dispatch_dest_tag, dispatch_rs1_tag, dispatch_rs1_value,
               dispatch_rs2_tag, dispatch_rs2_value, dispatch_payload,
        input  dispatch_ready,
        output cdb_valid, cdb_tag, cdb_value,
        input  issue_valid, issue_dest_tag, issue_rs1_value, issue_rs2_value, issue_payload,
        output issue_ready
    );

    modport slave (
        input  dispatch_valid, dispatch_dest_tag, dispatch_rs1_tag, dispatch_rs1_value,
               dispatch_rs2_tag, dispatch_rs2_value, dispatch_payload,
        output dispatch_ready,
        input  cdb_valid, cdb_tag, cdb_value,
        output issue_valid, issue_dest_tag, issue_rs1_value, issue_rs2_value, issue_payload,
        input  issue_ready
    );
endinterface

// File: rtl/rs_bank.sv
// rs_bank: reservation-station bank of RS_SIZE entries.
// Holds dispatched instructions until both source operands are available,
// captures operands from the CDB (also on the dispatch cycle itself) and
// issues one ready entry per cycle.
// Ports:
//   clock      : system clock
//   reset      : synchronous, active-high reset
//   squash     : flush every entry (branch mispredict); wins over all else
//   bus        : rs_bank_if.slave (dispatch, CDB snoop, issue)
//   free_count : registered number of free entries
// Build option:
//   RS_ROTATE_PRIO_EN defined   -> round-robin issue selection starting at a
//                                  pointer that moves past the last issued entry
//   RS_ROTATE_PRIO_EN undefined -> lowest-index ready entry always wins
module rs_bank #(
    parameter int RS_SIZE   = 8,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 64,
    localparam int CNT_W    = $clog2(RS_SIZE + 1),
    localparam int IDX_W    = $clog2(RS_SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    rs_bank_if.slave         bus,
    output logic [CNT_W-1:0] free_count
);

    logic [RS_SIZE-1:0]   busy_q;
    logic [TAG_W-1:0]     dest_tag_q  [RS_SIZE];
    logic [TAG_W-1:0]     rs1_tag_q   [RS_SIZE];
    logic [XLEN-1:0]      rs1_value_q [RS_SIZE];
    logic [TAG_W-1:0]     rs2_tag_q   [RS_SIZE];
    logic [XLEN-1:0]      rs2_value_q [RS_SIZE];
    logic [PAYLOAD_W-1:0] payload_q   [RS_SIZE];

    logic [RS_SIZE-1:0]   ready;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     free_idx;
    logic                 disp_fire;
    logic                 issue_fire;
    logic                 cdb_hit;
    logic [TAG_W-1:0]     new_rs1_tag;
    logic [XLEN-1:0]      new_rs1_value;
    logic [TAG_W-1:0]     new_rs2_tag;
    logic [XLEN-1:0]      new_rs2_value;

`ifdef RS_ROTATE_PRIO_EN
    logic [IDX_W-1:0]     ptr_q;
`endif

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy_q[i] && (rs1_tag_q[i] == '0) && (rs2_tag_q[i] == '0);
        end
    end

    // Issue selection works only on registered state, so a wakeup at edge N
    // becomes visible to issue in cycle N+1 (no CDB-to-issue bypass).
`ifdef RS_ROTATE_PRIO_EN
    always_comb begin
        int cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < RS_SIZE; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= RS_SIZE) begin
                cand = cand - RS_SIZE;
            end
            if (!sel_found && ready[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = RS_SIZE - 1; k >= 0; k--) begin
            if (ready[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // Lowest-index free entry; only used when free_count != 0, and an entry
    // issuing this cycle is still busy so it is never chosen here.
    always_comb begin
        free_idx = '0;
        for (int k = RS_SIZE - 1; k >= 0; k--) begin
            if (!busy_q[k]) begin
                free_idx = IDX_W'(k);
            end
        end
    end

    assign bus.dispatch_ready = (free_count != '0);
    assign disp_fire          = bus.dispatch_valid && bus.dispatch_ready;
    assign issue_fire         = sel_found && bus.issue_ready;
    assign cdb_hit            = bus.cdb_valid && (bus.cdb_tag != '0);

    // Dispatch-cycle forwarding: a source produced on the CDB this very cycle
    // would otherwise miss its broadcast and wait forever.
    always_comb begin
        new_rs1_tag   = bus.dispatch_rs1_tag;
        new_rs1_value = bus.dispatch_rs1_value;
        new_rs2_tag   = bus.dispatch_rs2_tag;
        new_rs2_value = bus.dispatch_rs2_value;
        if (cdb_hit && (bus.dispatch_rs1_tag == bus.cdb_tag)) begin
            new_rs1_tag   = '0;
            new_rs1_value = bus.cdb_value;
        end
        if (cdb_hit && (bus.dispatch_rs2_tag == bus.cdb_tag)) begin
            new_rs2_tag   = '0;
            new_rs2_value = bus.cdb_value;
        end
    end

    assign bus.issue_valid     = sel_found;
    assign bus.issue_dest_tag  = sel_found ? dest_tag_q[sel_idx]  : '0;
    assign bus.issue_rs1_value = sel_found ? rs1_value_q[sel_idx] : '0;
    assign bus.issue_rs2_value = sel_found ? rs2_value_q[sel_idx] : '0;
    assign bus.issue_payload   = sel_found ? payload_q[sel_idx]   : '0;

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            busy_q     <= '0;
            free_count <= CNT_W'(RS_SIZE);
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && cdb_hit) begin
                    if (rs1_tag_q[i] == bus.cdb_tag) begin
                        rs1_tag_q[i]   <= '0;
                        rs1_value_q[i] <= bus.cdb_value;
                    end
                    if (rs2_tag_q[i] == bus.cdb_tag) begin
                        rs2_tag_q[i]   <= '0;
                        rs2_value_q[i] <= bus.cdb_value;
                    end
                end
            end

            if (issue_fire) begin
                busy_q[sel_idx] <= 1'b0;
            end

            if (disp_fire) begin
                busy_q[free_idx]      <= 1'b1;
                dest_tag_q[free_idx]  <= bus.dispatch_dest_tag;
                rs1_tag_q[free_idx]   <= new_rs1_tag;
                rs1_value_q[free_idx] <= new_rs1_value;
                rs2_tag_q[free_idx]   <= new_rs2_tag;
                rs2_value_q[free_idx] <= new_rs2_value;
                payload_q[free_idx]   <= bus.dispatch_payload;
            end

            case ({disp_fire, issue_fire})
                2'b10:   free_count <= free_count - CNT_W'(1);
                2'b01:   free_count <= free_count + CNT_W'(1);
                default: free_count <= free_count;
            endcase
        end
    end

`ifdef RS_ROTATE_PRIO_EN
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            ptr_q <= '0;
        end else if (issue_fire) begin
            ptr_q <= (sel_idx == IDX_W'(RS_SIZE - 1)) ? '0 : sel_idx + IDX_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rs_bank.sv
module tb_rs_bank;
    localparam int N     = 8;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int PW    = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic       squash;
    logic [3:0] free_count;

    int errors = 0;
    int checks = 0;

    rs_bank_if #(.XLEN(XLEN), .TAG_W(TAG_W), .PAYLOAD_W(PW)) bus ();

    rs_bank #(.RS_SIZE(N), .XLEN(XLEN), .TAG_W(TAG_W), .PAYLOAD_W(PW)) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .bus        (bus),
        .free_count (free_count)
    );

    always #5 clock = ~clock;

    // ---------------- reference model: a table of pending instructions ----------------
    logic              m_busy [N];
    logic [TAG_W-1:0]  m_dest [N];
    logic [TAG_W-1:0]  m_t1   [N];
    logic [XLEN-1:0]   m_v1   [N];
    logic [TAG_W-1:0]  m_t2   [N];
    logic [XLEN-1:0]   m_v2   [N];
    logic [PW-1:0]     m_pay  [N];
    int                m_ptr = 0;

    function automatic int m_select();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (m_busy[idx] && m_t1[idx] == 0 && m_t2[idx] == 0) return idx;
        end
        return -1;
    endfunction

    function automatic int m_free();
        int n;
        n = 0;
        for (int k = 0; k < N; k++) if (!m_busy[k]) n++;
        return n;
    endfunction

    // Apply one clock of the model using the inputs present now, then advance the DUT.
    task automatic tick();
        int sel, nfree, slot;
        if (reset || squash) begin
            for (int k = 0; k < N; k++) m_busy[k] = 1'b0;
            m_ptr = 0;
        end else begin
            sel   = m_select();
            nfree = m_free();
            slot  = -1;
            for (int k = N - 1; k >= 0; k--) if (!m_busy[k]) slot = k;
            if (bus.cdb_valid && bus.cdb_tag != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_busy[k] && m_t1[k] == bus.cdb_tag) begin m_t1[k] = 0; m_v1[k] = bus.cdb_value; end
                    if (m_busy[k] && m_t2[k] == bus.cdb_tag) begin m_t2[k] = 0; m_v2[k] = bus.cdb_value; end
                end
            end
            if (sel >= 0 && bus.issue_ready) begin
                m_busy[sel] = 1'b0;
`ifdef RS_ROTATE_PRIO_EN
                m_ptr = (sel + 1) % N;
`endif
            end
            if (bus.dispatch_valid && nfree > 0) begin
                m_busy[slot] = 1'b1;
                m_dest[slot] = bus.dispatch_dest_tag;
                m_pay[slot]  = bus.dispatch_payload;
                m_t1[slot]   = bus.dispatch_rs1_tag;
                m_v1[slot]   = bus.dispatch_rs1_value;
                m_t2[slot]   = bus.dispatch_rs2_tag;
                m_v2[slot]   = bus.dispatch_rs2_value;
                if (bus.cdb_valid && bus.cdb_tag != 0 && bus.dispatch_rs1_tag == bus.cdb_tag) begin
                    m_t1[slot] = 0; m_v1[slot] = bus.cdb_value;
                end
                if (bus.cdb_valid && bus.cdb_tag != 0 && bus.dispatch_rs2_tag == bus.cdb_tag) begin
                    m_t2[slot] = 0; m_v2[slot] = bus.cdb_value;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset                  = 1'b0;
        squash                 = 1'b0;
        bus.dispatch_valid     = 1'b0;
        bus.dispatch_dest_tag  = '0;
        bus.dispatch_rs1_tag   = '0;
        bus.dispatch_rs1_value = '0;
        bus.dispatch_rs2_tag   = '0;
        bus.dispatch_rs2_value = '0;
        bus.dispatch_payload   = '0;
        bus.cdb_valid          = 1'b0;
        bus.cdb_tag            = '0;
        bus.cdb_value          = '0;
        bus.issue_ready        = 1'b0;
    endtask

    task automatic set_disp(input logic [TAG_W-1:0] dest, input logic [TAG_W-1:0] t1,
                            input logic [XLEN-1:0] v1, input logic [TAG_W-1:0] t2,
                            input logic [XLEN-1:0] v2, input logic [PW-1:0] pay);
        bus.dispatch_valid     = 1'b1;
        bus.dispatch_dest_tag  = dest;
        bus.dispatch_rs1_tag   = t1;
        bus.dispatch_rs1_value = v1;
        bus.dispatch_rs2_tag   = t2;
        bus.dispatch_rs2_value = v2;
        bus.dispatch_payload   = pay;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        set_disp(5'd2, 5'd0, 32'h1, 5'd0, 32'h2, 64'h3);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd1;
        tick();
        tick();
        idle_inputs();
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_free_count: got %0d expected 8", free_count); end
        checks++; if (bus.dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_dispatch_ready: got %0b expected 1", bus.dispatch_ready); end
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %0b expected 0", bus.issue_valid); end
        checks++; if (bus.issue_dest_tag !== 5'd0 || bus.issue_rs1_value !== 32'd0 || bus.issue_rs2_value !== 32'd0 || bus.issue_payload !== 64'd0) begin
            errors++; $display("FAIL reset_issue_data: got dest=%0h rs1=%0h rs2=%0h pay=%0h expected all 0",
                               bus.issue_dest_tag, bus.issue_rs1_value, bus.issue_rs2_value, bus.issue_payload);
        end
    endtask

    task automatic test_basic_issue();
        do_reset();
        bus.issue_ready = 1'b1;
        set_disp(5'd3, 5'd0, 32'h10, 5'd0, 32'h20, 64'hCAFE_0003);
        tick();
        bus.dispatch_valid = 1'b0;
        checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", bus.issue_valid); end
        checks++; if (bus.issue_dest_tag !== 5'd3) begin errors++; $display("FAIL basic_dest: got %0d expected 3", bus.issue_dest_tag); end
        checks++; if (bus.issue_rs1_value !== 32'h10 || bus.issue_rs2_value !== 32'h20) begin
            errors++; $display("FAIL basic_ops: got %0h/%0h expected 10/20", bus.issue_rs1_value, bus.issue_rs2_value);
        end
        checks++; if (bus.issue_payload !== 64'hCAFE_0003) begin errors++; $display("FAIL basic_payload: got %0h expected cafe0003", bus.issue_payload); end
        checks++; if (free_count !== 4'd7) begin errors++; $display("FAIL basic_free_busy: got %0d expected 7", free_count); end
        tick();
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL basic_free_after: got %0d expected 8", free_count); end
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %0b expected 0", bus.issue_valid); end
    endtask

    task automatic test_wakeup();
        do_reset();
        bus.issue_ready = 1'b1;
        set_disp(5'd4, 5'd7, 32'hFFFF, 5'd0, 32'h2, 64'h4);
        tick();
        bus.dispatch_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL wake_wait%0d: got %0b expected 0", c, bus.issue_valid); end
            tick();
        end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd7; bus.cdb_value = 32'hABCD;
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL wake_no_bypass: got %0b expected 0", bus.issue_valid); end
        tick();
        bus.cdb_valid = 1'b0;
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_dest_tag !== 5'd4) begin
            errors++; $display("FAIL wake_issue: got valid=%0b dest=%0d expected 1/4", bus.issue_valid, bus.issue_dest_tag);
        end
        checks++; if (bus.issue_rs1_value !== 32'hABCD || bus.issue_rs2_value !== 32'h2) begin
            errors++; $display("FAIL wake_ops: got %0h/%0h expected abcd/2", bus.issue_rs1_value, bus.issue_rs2_value);
        end
        tick();
        // A broadcast of tag 0 must not overwrite an operand that was ready at dispatch.
        bus.issue_ready = 1'b0;
        set_disp(5'd6, 5'd0, 32'h11, 5'd6, 32'h0, 64'h6);
        tick();
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd0; bus.cdb_value = 32'hDEAD;
        tick();
        bus.cdb_tag = 5'd6; bus.cdb_value = 32'h66;
        tick();
        bus.cdb_valid = 1'b0;
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_rs1_value !== 32'h11 || bus.issue_rs2_value !== 32'h66) begin
            errors++; $display("FAIL wake_tag0: got valid=%0b ops=%0h/%0h expected 1 11/66",
                               bus.issue_valid, bus.issue_rs1_value, bus.issue_rs2_value);
        end
    endtask

    task automatic test_dispatch_forward();
        do_reset();
        bus.issue_ready = 1'b1;
        set_disp(5'd5, 5'd0, 32'h1, 5'd9, 32'h0, 64'h5);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd9; bus.cdb_value = 32'h55;
        tick();
        idle_inputs();
        bus.issue_ready = 1'b1;
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_dest_tag !== 5'd5) begin
            errors++; $display("FAIL fwd_issue: got valid=%0b dest=%0d expected 1/5", bus.issue_valid, bus.issue_dest_tag);
        end
        checks++; if (bus.issue_rs2_value !== 32'h55 || bus.issue_rs1_value !== 32'h1) begin
            errors++; $display("FAIL fwd_ops: got %0h/%0h expected 1/55", bus.issue_rs1_value, bus.issue_rs2_value);
        end
        tick();
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL fwd_free: got %0d expected 8", free_count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_disp(TAG_W'(i + 1), TAG_W'(16 + i), 32'h0, 5'd0, 32'h7, 64'(i));
            tick();
        end
        set_disp(5'd30, 5'd0, 32'h1, 5'd0, 32'h2, 64'h9);
        checks++; if (bus.dispatch_ready !== 1'b0 || free_count !== 4'd0) begin
            errors++; $display("FAIL full_state: got ready=%0b free=%0d expected 0/0", bus.dispatch_ready, free_count);
        end
        tick();
        bus.dispatch_valid = 1'b0;
        checks++; if (bus.issue_valid !== 1'b0 || free_count !== 4'd0) begin
            errors++; $display("FAIL full_ignored: got valid=%0b free=%0d expected 0/0", bus.issue_valid, free_count);
        end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd16; bus.cdb_value = 32'h1600;
        tick();
        bus.cdb_valid = 1'b0;
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_dest_tag !== 5'd1 || bus.dispatch_ready !== 1'b0) begin
            errors++; $display("FAIL full_wake: got valid=%0b dest=%0d ready=%0b expected 1/1/0",
                               bus.issue_valid, bus.issue_dest_tag, bus.dispatch_ready);
        end
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        checks++; if (bus.dispatch_ready !== 1'b1 || free_count !== 4'd1) begin
            errors++; $display("FAIL full_freed: got ready=%0b free=%0d expected 1/1", bus.dispatch_ready, free_count);
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_disp(TAG_W'(i + 1), TAG_W'(20 + i), 32'h0, 5'd0, 32'h0, 64'h0);
            tick();
        end
        squash = 1'b1;
        set_disp(5'd9, 5'd0, 32'h99, 5'd0, 32'h98, 64'h9);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd20; bus.cdb_value = 32'h20;
        bus.issue_ready = 1'b1;
        tick();
        idle_inputs();
        bus.issue_ready = 1'b1;
        checks++; if (free_count !== 4'd8 || bus.dispatch_ready !== 1'b1) begin
            errors++; $display("FAIL squash_free: got free=%0d ready=%0b expected 8/1", free_count, bus.dispatch_ready);
        end
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL squash_valid: got %0b expected 0", bus.issue_valid); end
        tick();
        checks++; if (bus.issue_valid !== 1'b0 || free_count !== 4'd8) begin
            errors++; $display("FAIL squash_absent: got valid=%0b free=%0d expected 0/8", bus.issue_valid, free_count);
        end
    endtask

    // Entries 0 and 2 ready, the rest permanently waiting; the freed slot is refilled each round.
    task automatic test_priority();
        logic [TAG_W-1:0] exp_dest;
        do_reset();
        for (int i = 0; i < N; i++) begin
            if (i == 0 || i == 2) set_disp(TAG_W'(10 + i), 5'd0, 32'(i), 5'd0, 32'h0, 64'(i));
            else                  set_disp(TAG_W'(10 + i), 5'd31, 32'(i), 5'd0, 32'h0, 64'(i));
            tick();
        end
        bus.dispatch_valid = 1'b0;
        for (int r = 0; r < 6; r++) begin
`ifdef RS_ROTATE_PRIO_EN
            exp_dest = (r % 2 == 0) ? 5'd10 : 5'd12;
`else
            exp_dest = 5'd10;
`endif
            checks++; if (bus.issue_valid !== 1'b1 || bus.issue_dest_tag !== exp_dest) begin
                errors++; $display("FAIL prio_round%0d: got valid=%0b dest=%0d expected 1/%0d",
                                   r, bus.issue_valid, bus.issue_dest_tag, exp_dest);
            end
            bus.issue_ready = 1'b1;
            tick();
            bus.issue_ready = 1'b0;
            set_disp(exp_dest, 5'd0, 32'h100 + 32'(r), 5'd0, 32'h0, 64'(r));
            tick();
            bus.dispatch_valid = 1'b0;
        end
        checks++; if (free_count !== 4'd0) begin errors++; $display("FAIL prio_refilled: got %0d expected 0", free_count); end
    endtask

    // ---------------- randomized traffic against the model ----------------
    task automatic test_random();
        int sel, nfree;
        logic [TAG_W-1:0] e_dest;
        logic [XLEN-1:0]  e_v1, e_v2;
        logic [PW-1:0]    e_pay;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            idle_inputs();
            reset              = ($urandom_range(0, 199) == 0);
            squash             = ($urandom_range(0, 79) == 0);
            bus.dispatch_valid = ($urandom_range(0, 2) != 0);
            bus.dispatch_dest_tag  = TAG_W'($urandom_range(1, 31));
            bus.dispatch_rs1_tag   = ($urandom_range(0, 2) == 0) ? 5'd0 : TAG_W'($urandom_range(1, 7));
            bus.dispatch_rs2_tag   = ($urandom_range(0, 2) == 0) ? 5'd0 : TAG_W'($urandom_range(1, 7));
            bus.dispatch_rs1_value = $urandom;
            bus.dispatch_rs2_value = $urandom;
            bus.dispatch_payload   = {$urandom, $urandom};
            bus.cdb_valid          = ($urandom_range(0, 1) == 1);
            bus.cdb_tag            = TAG_W'($urandom_range(0, 7));
            bus.cdb_value          = $urandom;
            bus.issue_ready        = ($urandom_range(0, 3) != 0);
            tick();
            sel    = m_select();
            nfree  = m_free();
            e_dest = (sel >= 0) ? m_dest[sel] : '0;
            e_v1   = (sel >= 0) ? m_v1[sel]   : '0;
            e_v2   = (sel >= 0) ? m_v2[sel]   : '0;
            e_pay  = (sel >= 0) ? m_pay[sel]  : '0;
            checks++; if (bus.issue_valid !== (sel >= 0)) begin errors++; $display("FAIL rnd_valid c=%0d: got %0b expected %0b", c, bus.issue_valid, sel >= 0); end
            checks++; if (bus.issue_dest_tag !== e_dest) begin errors++; $display("FAIL rnd_dest c=%0d: got %0d expected %0d", c, bus.issue_dest_tag, e_dest); end
            checks++; if (bus.issue_rs1_value !== e_v1) begin errors++; $display("FAIL rnd_rs1 c=%0d: got %0h expected %0h", c, bus.issue_rs1_value, e_v1); end
            checks++; if (bus.issue_rs2_value !== e_v2) begin errors++; $display("FAIL rnd_rs2 c=%0d: got %0h expected %0h", c, bus.issue_rs2_value, e_v2); end
            checks++; if (bus.issue_payload !== e_pay) begin errors++; $display("FAIL rnd_payload c=%0d: got %0h expected %0h", c, bus.issue_payload, e_pay); end
            checks++; if (free_count !== 4'(nfree)) begin errors++; $display("FAIL rnd_free c=%0d: got %0d expected %0d", c, free_count, nfree); end
            checks++; if (bus.dispatch_ready !== (nfree != 0)) begin errors++; $display("FAIL rnd_dready c=%0d: got %0b expected %0b", c, bus.dispatch_ready, nfree != 0); end
        end
    endtask

    initial begin
        idle_inputs();
        @(posedge clock);
        #1;
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_dispatch_forward();
        test_full();
        test_squash();
        test_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Parametrised reservation-station bank of RS_SIZE entries.
- Accepts one dispatched instruction per cycle from decode/rename, with source tags from the map table and ready values from the regfile/ROB.
- Snoops one CDB broadcast per cycle to wake waiting operands, and issues one ready entry per cycle to the execute stage over a valid/ready handshake.
- Supports full squash on branch mispredict.

Parameters:
RS_SIZE, 8, number of entries (≥2, power of two not required)
XLEN, 32, operand value width
TAG_W, 5, ROB tag width; tag 0 reserved as "no tag / value ready"
PAYLOAD_W, 64, opaque decoded-instruction payload carried to issue

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
squash  in  1  flush all entries (mispredict)
dispatch_valid  in  1  new instruction offered
dispatch_ready  out  1  at least one free entry
dispatch_dest_tag  in  TAG_W  ROB tag of new instruction
dispatch_rs1_tag  in  TAG_W  source 1 tag, 0 = value valid
dispatch_rs1_value  in  XLEN  source 1 value (used when tag 0)
dispatch_rs2_tag  in  TAG_W  source 2 tag
dispatch_rs2_value  in  XLEN  source 2 value
dispatch_payload  in  PAYLOAD_W  decoded fields
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_value  in  XLEN  broadcast value
issue_valid  out  1  selected entry ready to issue
issue_ready  in  1  execute stage accepts
issue_dest_tag  out  TAG_W  selected entry dest tag
issue_rs1_value  out  XLEN  selected operand 1
issue_rs2_value  out  XLEN  selected operand 2
issue_payload  out  PAYLOAD_W  selected payload
free_count  out  $clog2(RS_SIZE+1)  number of free entries

Behaviour:
- Entry state: busy, dest_tag, rs1_tag/value, rs2_tag/value, payload. An entry is ready when busy && rs1_tag==0 && rs2_tag==0.
- Reset (synchronous) or squash: all busy cleared at the edge.
  - Outputs after the edge: free_count=RS_SIZE, dispatch_ready=1, issue_valid=0, issue_* data=0.
  - Rotation pointer resets to 0.
  - Squash takes priority over same-cycle dispatch, wakeup and issue: all are dropped.
- Dispatch:
  - Accepted when dispatch_valid && dispatch_ready.
  - Written at the edge into the lowest-index non-busy entry.
  - dispatch_ready = (free_count != 0). It does NOT count an entry freed by a same-cycle issue.
  - dispatch_valid while not ready is ignored; no state change.
- Dispatch forwarding: if cdb_valid && cdb_tag!=0 && cdb_tag equals a dispatched source tag, that source is stored with tag 0 and value cdb_value. Both sources are checked independently.
- Wakeup: for every busy entry, a source whose tag equals cdb_tag (cdb_valid, cdb_tag!=0) captures cdb_value and clears its tag at the edge.
  - Multiple entries and both sources may wake in the same cycle.
  - cdb_tag 0 never matches.
- Issue:
  - issue_valid and issue_* are combinational from registered entry state: the selected ready entry, or 0 when none is ready.
  - Latency: an entry dispatched ready, or woken at edge N, can issue in cycle N+1 at the earliest. There is no same-cycle CDB-to-issue bypass.
  - On issue_valid && issue_ready, the selected entry's busy is cleared at the edge.
  - With issue_ready=0, the selection holds stable unless a higher-priority entry becomes ready.
- Simultaneous dispatch + issue in one cycle: both take effect, and free_count is unchanged. Dispatch never targets the entry being issued in that cycle (that entry is still busy).
- Selection: fixed lowest-index-first among ready entries (see optional feature).
- free_count: registered. Updated as +1 on issue, −1 on dispatch, net 0 when both occur.

Optional Feature:
RS_ROTATE_PRIO_EN
- Defined:
  - A pointer ptr (reset 0) selects the first ready entry searching ptr, ptr+1, … RS_SIZE−1, 0, … ptr−1.
  - After an accepted issue from entry k, ptr = (k+1) mod RS_SIZE. ptr is unchanged when nothing issues.
- Undefined: no pointer; the lowest-index ready entry always wins.

Test Plan:
- Reset, then dispatch tag 3 with rs1_tag=0/val 0x10 and rs2_tag=0/val 0x20, issue_ready=1 → next cycle issue_valid=1, dest 3, ops 0x10/0x20; the cycle after, free_count=8, issue_valid=0.
- Dispatch tag 4 with rs1_tag=7; 2 cycles later cdb_valid, tag 7, value 0xABCD → issue_valid=0 until the edge after the CDB; then issue rs1=0xABCD.
- Dispatch with rs2_tag=9 in the same cycle as CDB tag 9/value 0x55 → entry stored ready; issues next cycle with rs2=0x55.
- Fill 8 entries with unready tags → dispatch_ready=0, free_count=0; a 9th dispatch is ignored; one CDB wakeup plus issue → dispatch_ready=1 the following cycle.
- 5 entries busy, then squash asserted alongside dispatch_valid and a CDB → next cycle free_count=8, issue_valid=0, dispatched instruction absent.
- RS_ROTATE_PRIO_EN defined, entries 0 and 2 held ready with issue_ready=1 and re-dispatched to refill → issues alternate 0, 2, 0, …; with the macro undefined, entry 0 repeatedly wins when refilled.
